branch_uop_queue: RTL
=====================

# branch_uop_queue

Sits directly downstream of the B-form decoder and buffers its decoded Branch Conditional micro-ops before branch-unit dispatch. At push time it resolves each branch's static target address, link address and CTR usage. It presents entries in order to the branch unit over a valid/ready handshake, and it back-pressures the decoder through `stall_o` early enough to absorb the decoder's one registered in-flight result.

## Interface
Parameters:
- addressWidth, 64, instruction/target address width
- instructionCounterWidth, 64, major ID width; the input/output port is this +1 bits wide, matching the decoder output
- PidSize, 32, process ID width
- TidSize, 64, thread ID width
- opcodeSize, 12, decoded opcode width
- bodyWidth, 28, decoder instruction body width (BO 5, BI 5, BD 14, 2 zero bits, AA, LK)
- queueDepth, 4, entries; power of two, ≥2

Ports:
- clock_i  in  1  sole clock; all state updates on the rising edge
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  push strobe from the decoder's enable_o
- opcode_i  in  opcodeSize  decoded opcode (25 = bc)
- instructionAddress_i  in  addressWidth  address of the branch
- instMajId_i  in  instructionCounterWidth+1  major ID
- is64Bit_i  in  1  64-bit mode
- instPid_i / instTid_i  in  PidSize / TidSize  process/thread ID
- instructionBody_i  in  bodyWidth  decoder body
- flush_i  in  1  discard all entries
- stall_o  out  1  stall to the decoder
- overflow_o  out  1  sticky: a push arrived while full
- valid_o  out  1  head entry valid
- ready_i  in  1  branch unit accepts head
- opcode_o, instMajId_o, instPid_o, instTid_o, is64Bit_o, BO_o(5), BI_o(5), LK_o  out  stored fields of the head entry
- target_o  out  addressWidth  resolved target
- linkAddr_o  out  addressWidth  address+4, written to LR when LK_o=1
- usesCtr_o  out  1  BO[2]==0 (bit 2 of the body, MSB-first)

## Operation
- Storage: circular buffer, read/write pointers of log2(queueDepth) bits that wrap naturally, and a count of log2(queueDepth)+1 bits.
- Push = enable_i && (count<queueDepth || pop). Pop = valid_o && ready_i.
- enable_i while full and not popping: the entry is dropped, overflow_o is set, and it stays set until reset.
- Target computation at push:
  - offset = sign-extend(BD‖00) to addressWidth.
  - AA=1: target = offset. AA=0: target = address+offset, modulo 2^addressWidth.
  - linkAddr = address+4.
  - is64Bit_i=0: bits [0:31] (MSB-first) of both target and linkAddr are forced to zero.
- stall_o = (queueDepth-count) ≤ 1, combinational from the registered count. This guarantees space for the decoder's in-flight result.
- Same-cycle push and pop, including when full: both occur and count is unchanged.
- flush_i has priority over push and pop:
  - pointers and count go to 0 on the next edge;
  - valid_o is 0 after that edge;
  - any push in the flush cycle is discarded;
  - overflow_o is not cleared.
- Reset (asserted asynchronously, any time): pointers, count and overflow_o → 0; valid_o → 0; stall_o → 0. All data outputs → 0; entry storage contents need not reset.

## Timing
- Push at edge t → entry is visible on valid_o/outputs after edge t (first-word-fall-through from the registered head). Latency 1 cycle into an empty queue.
- Head outputs are stable while valid_o=1 and ready_i=0.
- Pop at edge t → the next entry (or valid_o=0) appears after edge t.
- stall_o follows count with zero added latency after each edge.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package holds:
  - body field offsets (BO 0–4, BI 5–9, BD 10–23, AA 26, LK 27);
  - bc decoded opcode 25;
  - BranchUnitID 6.
- Sub-module `branch_target_calc`: combinational computation of target, linkAddr and usesCtr from address, body and is64Bit; instantiated once on the push path.

## Test plan
- Relative branch: addr 0x1000, BD=0x0004, AA=0, LK=1, 64-bit → target 0x1010, linkAddr 0x1004, LK_o=1, valid_o one cycle after push.
- Negative displacement: addr 0x1000, BD=0x3FFF, AA=0 → target 0x0FFC. Absolute: BD=0x0100, AA=1 → target 0x0400.
- 32-bit wrap: is64Bit=0, addr 0xFFFFFFFC, BD=0x0002 → target 0x00000004 with upper 32 bits zero; linkAddr 0x0.
- Fill with ready_i=0: stall_o rises once count=3. The fourth push is accepted (count 4). A fifth push sets overflow_o and is dropped. The next 4 pops return entries in order with majIds intact.
- Full queue with simultaneous push+pop → count stays 4, FIFO order preserved. BO=0b00100 → usesCtr_o=0; BO=0b00000 → usesCtr_o=1.
- flush_i with a concurrent push on a 2-entry queue → valid_o=0 next cycle, nothing is popped afterward. Asserting reset_i low mid-stream clears count, valid_o and overflow_o immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_uop_queue_pkg.sv
// Shared constants for the branch micro-op queue: decoder body field layout
// (bit positions counted MSB-first, as the decoder documents them) and unit IDs.
package branch_uop_queue_pkg;

  localparam int unsigned BoPos   = 0;
  localparam int unsigned BoWidth = 5;
  localparam int unsigned BiPos   = 5;
  localparam int unsigned BiWidth = 5;
  localparam int unsigned BdPos   = 10;
  localparam int unsigned BdWidth = 14;
  localparam int unsigned AaPos   = 26;
  localparam int unsigned LkPos   = 27;

  // BO bit 2 (MSB-first) clear means the branch decrements and tests CTR.
  localparam int unsigned BoCtrBit = 2;

  localparam int unsigned OpcBc        = 25;
  localparam int unsigned BranchUnitID = 6;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational static target / link address resolution for a bc micro-op.
module branch_target_calc
  import branch_uop_queue_pkg::*;
#(
  parameter int unsigned addressWidth = 64,
  parameter int unsigned bodyWidth    = 28
) (
  input  logic [addressWidth-1:0] address_i,
  input  logic [bodyWidth-1:0]    body_i,
  input  logic                    is64Bit_i,
  output logic [addressWidth-1:0] target_o,
  output logic [addressWidth-1:0] linkAddr_o,
  output logic                    usesCtr_o
);

  localparam logic [addressWidth-1:0] Low32Mask = addressWidth'(64'hFFFF_FFFF);

  logic [BdWidth-1:0]      bd;
  logic                    aa;
  logic [addressWidth-1:0] offset;
  logic [addressWidth-1:0] target_raw;
  logic [addressWidth-1:0] link_raw;
  logic [addressWidth-1:0] mode_mask;
  logic                    unused_body;

  assign bd = body_i[bodyWidth-1-BdPos -: BdWidth];
  assign aa = body_i[bodyWidth-1-AaPos];

  assign offset     = {{(addressWidth-BdWidth-2){bd[BdWidth-1]}}, bd, 2'b00};
  assign target_raw = aa ? offset : (address_i + offset);
  assign link_raw   = address_i + addressWidth'(4);

  // 32-bit mode clears the upper word of both addresses.
  assign mode_mask  = is64Bit_i ? '1 : Low32Mask;
  assign target_o   = target_raw & mode_mask;
  assign linkAddr_o = link_raw & mode_mask;
  assign usesCtr_o  = ~body_i[bodyWidth-1-BoCtrBit];

  assign unused_body = ^{body_i[bodyWidth-1 -: 2],
                         body_i[bodyWidth-4 -: 2+BiWidth],
                         body_i[bodyWidth-1-BdPos-BdWidth -: 2],
                         body_i[bodyWidth-1-LkPos]};

endmodule

// File: rtl/branch_uop_queue.sv
// In-order buffer of decoded bc micro-ops between the B-form decoder and the
// branch unit; targets are resolved on push, head is presented first-word-fall-through.
module branch_uop_queue
  import branch_uop_queue_pkg::*;
#(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned PidSize                 = 32,
  parameter int unsigned TidSize                 = 64,
  parameter int unsigned opcodeSize              = 12,
  parameter int unsigned bodyWidth               = 28,
  parameter int unsigned queueDepth              = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [instructionCounterWidth:0]   instMajId_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instPid_i,
  input  logic [TidSize-1:0]                 instTid_i,
  input  logic [bodyWidth-1:0]               instructionBody_i,
  input  logic                               flush_i,
  output logic                               stall_o,
  output logic                               overflow_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [instructionCounterWidth:0]   instMajId_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic                               is64Bit_o,
  output logic [4:0]                         BO_o,
  output logic [4:0]                         BI_o,
  output logic                               LK_o,
  output logic [addressWidth-1:0]            target_o,
  output logic [addressWidth-1:0]            linkAddr_o,
  output logic                               usesCtr_o
);

  localparam int unsigned PtrW = $clog2(queueDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(queueDepth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic full, valid, push, pop, wr_en;

  logic [addressWidth-1:0] calc_target;
  logic [addressWidth-1:0] calc_link;
  logic                    calc_uses_ctr;

  logic [opcodeSize-1:0]            opc_q  [queueDepth];
  logic [instructionCounterWidth:0] maj_q  [queueDepth];
  logic [PidSize-1:0]               pid_q  [queueDepth];
  logic [TidSize-1:0]               tid_q  [queueDepth];
  logic                             b64_q  [queueDepth];
  logic [4:0]                       bo_q   [queueDepth];
  logic [4:0]                       bi_q   [queueDepth];
  logic                             lk_q   [queueDepth];
  logic [addressWidth-1:0]          tgt_q  [queueDepth];
  logic [addressWidth-1:0]          lnk_q  [queueDepth];
  logic                             ctr_q  [queueDepth];

  branch_target_calc #(
    .addressWidth (addressWidth),
    .bodyWidth    (bodyWidth)
  ) u_target_calc (
    .address_i  (instructionAddress_i),
    .body_i     (instructionBody_i),
    .is64Bit_i  (is64Bit_i),
    .target_o   (calc_target),
    .linkAddr_o (calc_link),
    .usesCtr_o  (calc_uses_ctr)
  );

  assign full  = (count_q == Depth);
  assign valid = (count_q != '0);
  assign pop   = valid && ready_i;
  assign push  = enable_i && (!full || pop);
  assign wr_en = push && !flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (enable_i & full & ~pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      opc_q[wr_ptr_q] <= opcode_i;
      maj_q[wr_ptr_q] <= instMajId_i;
      pid_q[wr_ptr_q] <= instPid_i;
      tid_q[wr_ptr_q] <= instTid_i;
      b64_q[wr_ptr_q] <= is64Bit_i;
      bo_q[wr_ptr_q]  <= instructionBody_i[bodyWidth-1-BoPos -: BoWidth];
      bi_q[wr_ptr_q]  <= instructionBody_i[bodyWidth-1-BiPos -: BiWidth];
      lk_q[wr_ptr_q]  <= instructionBody_i[bodyWidth-1-LkPos];
      tgt_q[wr_ptr_q] <= calc_target;
      lnk_q[wr_ptr_q] <= calc_link;
      ctr_q[wr_ptr_q] <= calc_uses_ctr;
    end
  end

  // Storage is not reset, so head data is gated to zero whenever empty.
  assign valid_o     = valid;
  assign stall_o     = (Depth - count_q) <= CntW'(1);
  assign overflow_o  = overflow_q;
  assign opcode_o    = valid ? opc_q[rd_ptr_q] : '0;
  assign instMajId_o = valid ? maj_q[rd_ptr_q] : '0;
  assign instPid_o   = valid ? pid_q[rd_ptr_q] : '0;
  assign instTid_o   = valid ? tid_q[rd_ptr_q] : '0;
  assign is64Bit_o   = valid ? b64_q[rd_ptr_q] : 1'b0;
  assign BO_o        = valid ? bo_q[rd_ptr_q]  : '0;
  assign BI_o        = valid ? bi_q[rd_ptr_q]  : '0;
  assign LK_o        = valid ? lk_q[rd_ptr_q]  : 1'b0;
  assign target_o    = valid ? tgt_q[rd_ptr_q] : '0;
  assign linkAddr_o  = valid ? lnk_q[rd_ptr_q] : '0;
  assign usesCtr_o   = valid ? ctr_q[rd_ptr_q] : 1'b0;

endmodule
